// File: rtl/psx_host_port.sv
// PlayStation controller-port host: clocks one byte out on PSX_cmd (LSB first) while shifting PSX_dat in, then waits for ACK.
// Build option PSX_HOST_AUTO_DESELECT_EN: an ACK timeout ends the packet on its own instead of returning to S_READY.
module psx_host_port #(
    parameter int CLOCK_MHZ      = 12,
    parameter int HALF_PERIOD_US = 2,
    parameter int ACK_TIMEOUT_US = 100
) (
    input  logic       clk,
    input  logic       reset,
    output logic       PSX_clk,
    output logic       PSX_sel,
    output logic       PSX_cmd,
    input  logic       PSX_dat,
    input  logic       PSX_ack,
    input  logic       packet_start,
    input  logic       packet_end,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       rx_acked,
    output logic       busy
);

    localparam int HALF    = CLOCK_MHZ * HALF_PERIOD_US;
    localparam int TIMEOUT = CLOCK_MHZ * ACK_TIMEOUT_US;
    localparam int CNT_MAX = (TIMEOUT > 2 * HALF) ? TIMEOUT : 2 * HALF;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_READY, S_BIT_LOW, S_BIT_HIGH, S_ACK_WAIT, S_DESELECT
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    tx_shift, tx_shift_next;
    logic [7:0]    rx_shift;
    logic          ack_seen;
    logic          dat_s1, dat_s2, ack_s1, ack_s2;
    logic          half_done, hold_done, timeout_hit, acked_now, leave_ack;
    logic          sel_d, clk_d, cmd_d;

    assign half_done   = (cnt == CW'(HALF - 1));
    assign hold_done   = (cnt == CW'(2 * HALF - 1));
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
    assign acked_now   = !ack_s2 || ack_seen;
    assign leave_ack   = (state == S_ACK_WAIT) && (next_state != S_ACK_WAIT);
    assign tx_ready    = (state == S_READY) && !packet_end;
    assign busy        = (state != S_IDLE);

    // Both device lines idle high (pull-ups), so the synchronizers reset high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
            ack_s1 <= 1'b1;
            ack_s2 <= 1'b1;
        end else begin
            dat_s1 <= PSX_dat;
            dat_s2 <= dat_s1;
            ack_s1 <= PSX_ack;
            ack_s2 <= ack_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state || state == S_IDLE || state == S_READY)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        next_state    = state;
        tx_shift_next = tx_shift;
        case (state)
            S_IDLE:     if (packet_start) next_state = S_SELECT;
            S_SELECT:   if (half_done) next_state = S_READY;
            S_READY: begin
                if (packet_end) begin
                    next_state = S_DESELECT;
                end else if (tx_valid) begin
                    next_state    = S_BIT_LOW;
                    tx_shift_next = tx_data;
                end
            end
            S_BIT_LOW:  if (half_done) next_state = S_BIT_HIGH;
            S_BIT_HIGH: begin
                if (half_done) begin
                    if (bit_idx == 3'd7) begin
                        next_state = S_ACK_WAIT;
                    end else begin
                        next_state    = S_BIT_LOW;
                        tx_shift_next = {1'b1, tx_shift[7:1]};
                    end
                end
            end
            S_ACK_WAIT: begin
                if (acked_now) begin
                    next_state = S_READY;
                end else if (timeout_hit) begin
`ifdef PSX_HOST_AUTO_DESELECT_EN
                    next_state = S_DESELECT;
`else
                    next_state = S_READY;
`endif
                end
            end
            S_DESELECT: if (hold_done) next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Pins are decoded from the next state and registered, so they switch on the same edge as the state.
    always_comb begin
        sel_d = (next_state == S_IDLE) || (next_state == S_DESELECT);
        clk_d = (next_state != S_BIT_LOW);
        cmd_d = 1'b1;
        if (next_state == S_BIT_LOW || next_state == S_BIT_HIGH)
            cmd_d = tx_shift_next[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PSX_sel <= 1'b1;
            PSX_clk <= 1'b1;
            PSX_cmd <= 1'b1;
        end else begin
            PSX_sel <= sel_d;
            PSX_clk <= clk_d;
            PSX_cmd <= cmd_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_shift <= 8'hFF;
            rx_shift <= 8'hFF;
            bit_idx  <= 3'd0;
            ack_seen <= 1'b0;
        end else begin
            tx_shift <= tx_shift_next;
            if (state == S_READY && next_state == S_BIT_LOW) begin
                bit_idx  <= 3'd0;
                ack_seen <= 1'b0;
            end else if (state == S_BIT_HIGH && next_state == S_BIT_LOW) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (state == S_BIT_HIGH && cnt == '0)
                rx_shift <= {dat_s2, rx_shift[7:1]};
            // A device that acknowledges early, while the last bit is still high, still counts as acked.
            if (state == S_BIT_HIGH && bit_idx == 3'd7 && !ack_s2)
                ack_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_strobe <= 1'b0;
            rx_acked  <= 1'b0;
            rx_data   <= 8'hFF;
        end else begin
            rx_strobe <= leave_ack;
            if (leave_ack) begin
                rx_data  <= rx_shift;
                rx_acked <= acked_now;
            end
        end
    end

endmodule

// File: tb/tb_psx_host_port.sv
// Bench for psx_host_port: a behavioural PSX device answers each byte, and results are checked against that device's view.
module tb_psx_host_port;

    localparam int CLOCK_MHZ  = 12;
    localparam int HALF       = CLOCK_MHZ * 2;
    localparam int TIMEOUT    = CLOCK_MHZ * 100;
    localparam int ACK_DELAY  = CLOCK_MHZ * 10;
    localparam int BYTE_LIMIT = 16 * HALF + TIMEOUT + 400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       PSX_clk, PSX_sel, PSX_cmd;
    logic       PSX_dat = 1'b1;
    logic       PSX_ack = 1'b1;
    logic       packet_start = 1'b0;
    logic       packet_end = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_strobe, rx_acked, busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    psx_host_port dut (
        .clk(clk), .reset(reset), .PSX_clk(PSX_clk), .PSX_sel(PSX_sel), .PSX_cmd(PSX_cmd),
        .PSX_dat(PSX_dat), .PSX_ack(PSX_ack), .packet_start(packet_start), .packet_end(packet_end),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_strobe(rx_strobe), .rx_acked(rx_acked), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Device model: drives reply bits on falling PSX_clk, samples PSX_cmd on rising PSX_clk, ACKs after 8 bits.
    logic [7:0] dev_reply = 8'hFF;
    logic [7:0] dev_rx = 8'h00;
    logic [7:0] dev_last_rx = 8'h00;
    logic       dev_prev_clk = 1'b1;
    bit         dev_ack_en = 1'b1;
    int         dev_bits = 0;
    int         dev_ack_delay = ACK_DELAY;
    int         dev_ack_len = HALF;
    int         ack_at = -1;

    always @(PSX_clk or PSX_sel) begin
        if (PSX_sel) begin
            dev_bits = 0;
            PSX_dat  = 1'b1;
        end else if (dev_prev_clk && !PSX_clk && dev_bits < 8) begin
            PSX_dat = dev_reply[dev_bits];
        end else if (!dev_prev_clk && PSX_clk && dev_bits < 8) begin
            dev_rx[dev_bits] = PSX_cmd;
            dev_bits++;
            if (dev_bits == 8) begin
                dev_bits    = 0;
                dev_last_rx = dev_rx;
                if (dev_ack_en) ack_at = cyc + dev_ack_delay;
            end
        end
        dev_prev_clk = PSX_clk;
    end

    always @(negedge clk) PSX_ack = !(ack_at >= 0 && cyc >= ack_at && cyc < ack_at + dev_ack_len);

    // Observations of the most recent byte transfer.
    bit         r_got;
    int         r_falls, r_min_low, r_max_low, r_first_fall, r_last_rise, r_strobe_cyc;
    int         sel_fall_cyc;
    logic [7:0] r_rx_data, r_rx_before;
    logic       r_rx_acked, r_strobe_next, r_sel_at_strobe, r_ready_at_strobe;

    task automatic start_packet();
        @(negedge clk);
        packet_start = 1'b1;
        @(negedge clk);
        packet_start = 1'b0;
        sel_fall_cyc = cyc;
    endtask

    task automatic run_byte(input logic [7:0] tx, input logic [7:0] reply, input bit ack_en);
        int   low_start;
        logic prev;
        r_got = 1'b0; r_falls = 0; r_min_low = 1 << 30; r_max_low = 0;
        r_first_fall = -1; r_last_rise = -1; r_strobe_cyc = -1;
        r_rx_data = 8'hxx; r_rx_acked = 1'bx; r_strobe_next = 1'bx;
        dev_reply = reply;
        dev_ack_en = ack_en;
        tx_data = tx;
        tx_valid = 1'b1;
        for (int i = 0; i < BYTE_LIMIT && !tx_ready; i++) @(negedge clk);
        r_rx_before = rx_data;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        prev = 1'b1;
        low_start = cyc;
        for (int i = 0; i < BYTE_LIMIT; i++) begin
            if (prev && !PSX_clk) begin
                r_falls++;
                low_start = cyc;
                if (r_first_fall < 0) r_first_fall = cyc;
            end
            if (!prev && PSX_clk) begin
                if (cyc - low_start < r_min_low) r_min_low = cyc - low_start;
                if (cyc - low_start > r_max_low) r_max_low = cyc - low_start;
                r_last_rise = cyc;
            end
            prev = PSX_clk;
            if (rx_strobe) begin
                r_got = 1'b1; r_strobe_cyc = cyc; r_rx_data = rx_data; r_rx_acked = rx_acked;
                r_sel_at_strobe = PSX_sel; r_ready_at_strobe = tx_ready;
                @(negedge clk);
                r_strobe_next = rx_strobe;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (PSX_sel !== 1'b1) begin n_errors++; $display("FAIL reset_sel got %b expected 1", PSX_sel); end
        n_checks++; if (PSX_clk !== 1'b1) begin n_errors++; $display("FAIL reset_clk got %b expected 1", PSX_clk); end
        n_checks++; if (PSX_cmd !== 1'b1) begin n_errors++; $display("FAIL reset_cmd got %b expected 1", PSX_cmd); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_checks++; if (tx_ready !== 1'b0) begin n_errors++; $display("FAIL reset_tx_ready got %b expected 0", tx_ready); end
        n_checks++; if (rx_data !== 8'hFF) begin n_errors++; $display("FAIL reset_rx_data got %h expected ff", rx_data); end
        n_checks++; if (rx_strobe !== 1'b0 || rx_acked !== 1'b0) begin n_errors++; $display("FAIL reset_rx_flags got %b%b expected 00", rx_strobe, rx_acked); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || PSX_sel !== 1'b1) begin n_errors++; $display("FAIL idle_after_reset busy/sel got %b/%b expected 0/1", busy, PSX_sel); end
    endtask

    task automatic test_first_byte();
        start_packet();
        n_checks++; if (PSX_sel !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL select sel/busy got %b/%b expected 0/1", PSX_sel, busy); end
        run_byte(8'h01, 8'hFF, 1'b1);
        n_checks++; if (!r_got) begin n_errors++; $display("FAIL first_strobe got none expected rx_strobe"); end
        n_checks++; if (r_first_fall - sel_fall_cyc !== HALF + 1) begin n_errors++; $display("FAIL sel_to_first_fall got %0d expected %0d", r_first_fall - sel_fall_cyc, HALF + 1); end
        n_checks++; if (r_falls !== 8) begin n_errors++; $display("FAIL first_clk_pulses got %0d expected 8", r_falls); end
        n_checks++; if (r_min_low !== HALF || r_max_low !== HALF) begin n_errors++; $display("FAIL first_low_width got %0d..%0d expected %0d", r_min_low, r_max_low, HALF); end
        n_checks++; if (dev_last_rx !== 8'h01) begin n_errors++; $display("FAIL first_cmd_bits got %h expected 01", dev_last_rx); end
        n_checks++; if (r_rx_data !== 8'hFF || r_rx_acked !== 1'b1) begin n_errors++; $display("FAIL first_rx data/acked got %h/%b expected ff/1", r_rx_data, r_rx_acked); end
        n_checks++; if (r_strobe_next !== 1'b0) begin n_errors++; $display("FAIL strobe_width got %b one cycle later expected 0", r_strobe_next); end
    endtask

    task automatic test_second_byte();
        run_byte(8'h42, 8'h41, 1'b1);
        n_checks++; if (r_rx_before !== 8'hFF) begin n_errors++; $display("FAIL rx_hold got %h expected ff", r_rx_before); end
        n_checks++; if (dev_last_rx !== 8'h42) begin n_errors++; $display("FAIL second_cmd_bits got %h expected 42", dev_last_rx); end
        n_checks++; if (r_rx_data !== 8'h41 || r_rx_acked !== 1'b1) begin n_errors++; $display("FAIL second_rx data/acked got %h/%b expected 41/1", r_rx_data, r_rx_acked); end
    endtask

    task automatic test_random_bytes();
        logic [7:0] prev_reply, tx, rp;
        prev_reply = 8'h41;
        for (int k = 0; k < 5; k++) begin
            tx = 8'($urandom);
            rp = 8'($urandom);
            run_byte(tx, rp, 1'b1);
            n_checks++; if (r_rx_before !== prev_reply) begin n_errors++; $display("FAIL rand_rx_hold[%0d] got %h expected %h", k, r_rx_before, prev_reply); end
            n_checks++; if (dev_last_rx !== tx) begin n_errors++; $display("FAIL rand_cmd[%0d] got %h expected %h", k, dev_last_rx, tx); end
            n_checks++; if (r_rx_data !== rp || r_rx_acked !== 1'b1) begin n_errors++; $display("FAIL rand_rx[%0d] data/acked got %h/%b expected %h/1", k, r_rx_data, r_rx_acked, rp); end
            n_checks++; if (r_falls !== 8) begin n_errors++; $display("FAIL rand_pulses[%0d] got %0d expected 8", k, r_falls); end
            prev_reply = rp;
        end
    endtask

    task automatic test_early_ack();
        logic [7:0] rp;
        rp = 8'($urandom);
        dev_ack_delay = 2;
        dev_ack_len = 8;
        run_byte(8'hA5, rp, 1'b1);
        dev_ack_delay = ACK_DELAY;
        dev_ack_len = HALF;
        n_checks++; if (r_rx_data !== rp || r_rx_acked !== 1'b1) begin n_errors++; $display("FAIL early_ack data/acked got %h/%b expected %h/1", r_rx_data, r_rx_acked, rp); end
        n_checks++; if (!r_got || r_strobe_cyc - r_last_rise >= HALF + TIMEOUT) begin n_errors++; $display("FAIL early_ack_latency got %0d expected below %0d", r_strobe_cyc - r_last_rise, HALF + TIMEOUT); end
    endtask

    task automatic test_timeout();
        logic [7:0] rp;
        rp = 8'($urandom);
        run_byte(8'h01, rp, 1'b0);
        n_checks++; if (!r_got || r_strobe_cyc - r_last_rise !== HALF + TIMEOUT) begin n_errors++; $display("FAIL timeout_latency got %0d expected %0d", r_strobe_cyc - r_last_rise, HALF + TIMEOUT); end
        n_checks++; if (r_rx_acked !== 1'b0 || r_rx_data !== rp) begin n_errors++; $display("FAIL timeout_rx data/acked got %h/%b expected %h/0", r_rx_data, r_rx_acked, rp); end
`ifdef PSX_HOST_AUTO_DESELECT_EN
        n_checks++; if (r_sel_at_strobe !== 1'b1 || r_ready_at_strobe !== 1'b0) begin n_errors++; $display("FAIL timeout_deselect sel/ready got %b/%b expected 1/0", r_sel_at_strobe, r_ready_at_strobe); end
        for (int i = 0; i < 4 * HALF && busy; i++) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL timeout_idle busy got %b expected 0", busy); end
`else
        n_checks++; if (r_ready_at_strobe !== 1'b1 || r_sel_at_strobe !== 1'b0) begin n_errors++; $display("FAIL timeout_ready ready/sel got %b/%b expected 1/0", r_ready_at_strobe, r_sel_at_strobe); end
`endif
    endtask

    task automatic test_deselect();
        int  desel_cyc;
        bit  clk_low_seen, sel_low_seen;
        if (!busy) start_packet();
        for (int i = 0; i < 4 * HALF && !tx_ready; i++) @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_errors++; $display("FAIL deselect_ready got %b expected 1", tx_ready); end
        packet_end = 1'b1; tx_valid = 1'b1; tx_data = 8'h43;
        #1;
        n_checks++; if (tx_ready !== 1'b0) begin n_errors++; $display("FAIL end_blocks_ready got %b expected 0", tx_ready); end
        @(negedge clk);
        packet_end = 1'b0; tx_valid = 1'b0;
        desel_cyc = cyc;
        clk_low_seen = 1'b0; sel_low_seen = 1'b0;
        for (int i = 0; i < 4 * HALF && busy; i++) begin
            packet_start = (i == 10);
            if (!PSX_clk) clk_low_seen = 1'b1;
            if (!PSX_sel) sel_low_seen = 1'b1;
            @(negedge clk);
        end
        packet_start = 1'b0;
        n_checks++; if (cyc - desel_cyc !== 2 * HALF) begin n_errors++; $display("FAIL deselect_hold got %0d expected %0d", cyc - desel_cyc, 2 * HALF); end
        n_checks++; if (clk_low_seen || sel_low_seen) begin n_errors++; $display("FAIL deselect_pins clk_low/sel_low got %b/%b expected 0/0", clk_low_seen, sel_low_seen); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || PSX_sel !== 1'b1) begin n_errors++; $display("FAIL start_ignored busy/sel got %b/%b expected 0/1", busy, PSX_sel); end
    endtask

    task automatic test_reset_mid_byte();
        bit         strobe_seen, sel_low_seen;
        logic [7:0] tx, rp;
        start_packet();
        dev_reply = 8'h5A;
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        for (int i = 0; i < 4 * HALF && !tx_ready; i++) @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < BYTE_LIMIT && !(dev_bits == 3 && !PSX_clk); i++) @(negedge clk);
        n_checks++; if (dev_bits !== 3 || PSX_clk !== 1'b0) begin n_errors++; $display("FAIL reach_bit3 bits/clk got %0d/%b expected 3/0", dev_bits, PSX_clk); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (PSX_clk !== 1'b1 || PSX_sel !== 1'b1 || PSX_cmd !== 1'b1) begin n_errors++; $display("FAIL async_reset clk/sel/cmd got %b/%b/%b expected 1/1/1", PSX_clk, PSX_sel, PSX_cmd); end
        n_checks++; if (busy !== 1'b0 || tx_ready !== 1'b0 || rx_data !== 8'hFF) begin n_errors++; $display("FAIL async_reset busy/ready/rx got %b/%b/%h expected 0/0/ff", busy, tx_ready, rx_data); end
        strobe_seen = 1'b0; sel_low_seen = 1'b0;
        repeat (3) begin @(negedge clk); if (rx_strobe) strobe_seen = 1'b1; end
        reset = 1'b1;
        for (int i = 0; i < 3 * HALF; i++) begin
            @(negedge clk);
            if (rx_strobe) strobe_seen = 1'b1;
            if (!PSX_sel) sel_low_seen = 1'b1;
        end
        n_checks++; if (strobe_seen || sel_low_seen) begin n_errors++; $display("FAIL partial_byte strobe/sel_low got %b/%b expected 0/0", strobe_seen, sel_low_seen); end
        start_packet();
        tx = 8'($urandom);
        rp = 8'($urandom);
        run_byte(tx, rp, 1'b1);
        n_checks++; if (r_rx_data !== rp || r_rx_acked !== 1'b1 || dev_last_rx !== tx) begin n_errors++; $display("FAIL after_reset rx/acked/cmd got %h/%b/%h expected %h/1/%h", r_rx_data, r_rx_acked, dev_last_rx, rp, tx); end
        for (int i = 0; i < 4 * HALF && !tx_ready; i++) @(negedge clk);
        packet_end = 1'b1;
        @(negedge clk);
        packet_end = 1'b0;
        for (int i = 0; i < 4 * HALF && busy; i++) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || PSX_sel !== 1'b1) begin n_errors++; $display("FAIL final_end busy/sel got %b/%b expected 0/1", busy, PSX_sel); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_byte();
        test_second_byte();
        test_random_bytes();
        test_early_ack();
        test_timeout();
        test_deselect();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
